div_rep_sub_unit: RTL and testbench

//  Unsigned integer divider using repeated subtraction; a control FSM drives a datapath.

---
 rtl/div_rep_sub_pkg.sv | 16 +
 rtl/div_rep_sub_datapath.sv | 60 ++++++
 rtl/div_rep_sub_unit.sv | 124 ++++++++++++
 tb/tb_div_rep_sub_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/div_rep_sub_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package div_rep_sub_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_LOAD_N = 3'd2,
    ST_LOAD_D = 3'd3,
    ST_SUB    = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/div_rep_sub_datapath.sv
// Datapath for the repeated-subtraction divider: R, D, Q registers,
// subtractor, incrementer and unsigned comparator.
module div_rep_sub_datapath
  import div_rep_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ld_r,
  input  logic             ld_d,
  input  logic             clr_q,
  input  logic             set_q,
  input  logic             inc_q,
  input  logic             sub_r,
  output logic             r_ge_d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] d;

  // Unsigned compare straight from the registers gates the subtract
  assign r_ge_d = (r >= d);

  // Remainder register: loaded with the dividend, then reduced by D
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r <= '0;
    end else if (ld_r) begin
      r <= data_in;
    end else if (sub_r) begin
      r <= WIDTH'(r - d);
    end
  end

  // Divisor register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
    end else if (ld_d) begin
      d <= data_in;
    end
  end

  // Quotient register: all ones flags a zero divisor, otherwise counts subtracts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (set_q) begin
      q <= '1;
    end else if (clr_q) begin
      q <= '0;
    end else if (inc_q) begin
      q <= WIDTH'(q + WIDTH'(1));
    end
  end

endmodule

// File: rtl/div_rep_sub_unit.sv
// Unsigned divider by repeated subtraction: control FSM plus registered flags,
// driving div_rep_sub_datapath. Operands arrive serially on data_in.
module div_rep_sub_unit
  import div_rep_sub_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  state_e state, state_nxt;
  logic   busy_nxt, done_nxt, dz_nxt;
  logic   ld_r, ld_d, clr_q, set_q, inc_q, sub_r;
  logic   r_ge_d;

  // State and output flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      div_by_zero <= dz_nxt;
    end
  end

  // Next-state, flag and datapath control decode
  always_comb begin
    state_nxt = state;
    busy_nxt  = busy;
    done_nxt  = done;
    dz_nxt    = div_by_zero;
    ld_r      = 1'b0;
    ld_d      = 1'b0;
    clr_q     = 1'b0;
    set_q     = 1'b0;
    inc_q     = 1'b0;
    sub_r     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WAIT;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          dz_nxt    = 1'b0;
        end
      end
      ST_WAIT: begin
        state_nxt = ST_LOAD_N;
      end
      ST_LOAD_N: begin
        ld_r      = 1'b1;
        state_nxt = ST_LOAD_D;
      end
      ST_LOAD_D: begin
        ld_d  = 1'b1;
        clr_q = 1'b1;
        if (data_in == '0) begin
          set_q     = 1'b1;
          dz_nxt    = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_SUB;
        end
      end
      ST_SUB: begin
        if (r_ge_d) begin
          inc_q = 1'b1;
          sub_r = 1'b1;
        end else begin
          state_nxt = ST_DONE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      ST_DONE: begin
        // A zero divisor enters here without a compare cycle, so done
        // rises one cycle later, keeping the one-exit-cycle latency.
        if (start) begin
          state_nxt = ST_WAIT;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          dz_nxt    = 1'b0;
        end else begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  div_rep_sub_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_in (data_in),
    .ld_r    (ld_r),
    .ld_d    (ld_d),
    .clr_q   (clr_q),
    .set_q   (set_q),
    .inc_q   (inc_q),
    .sub_r   (sub_r),
    .r_ge_d  (r_ge_d),
    .q       (quotient),
    .r       (remainder)
  );

endmodule

// File: tb/tb_div_rep_sub_unit.sv
// Self-checking bench for div_rep_sub_unit: directed edge cases plus random
// operands checked against plain / and % arithmetic.
module tb_div_rep_sub_unit;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] data_in;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  div_rep_sub_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue start at edge E and present dividend at E+2, divisor at E+3.
  task automatic start_and_load(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    @(negedge clk);
    start   = 1'b1;
    data_in = W'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, " busy@E"}, 32'(busy), 32'd1);
    check({tag, " done@E"}, 32'(done), 32'd0);
    check({tag, " dz@E"}, 32'(div_by_zero), 32'd0);
    @(negedge clk);
    data_in = W'($urandom);
    @(posedge clk);
    @(negedge clk);
    data_in = a;
    @(posedge clk);
    @(negedge clk);
    data_in = b;
    @(posedge clk);
    #1;
  endtask

  // Full division with latency and result checks; pulse_n >= 0 pulses start
  // so it is sampled at edge E+pulse_n.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input int pulse_n, input string tag);
    int           n;
    int           exp_lat;
    logic [W-1:0] exp_q;
    logic [W-1:0] exp_r;
    logic         exp_dz;
    if (b == 0) begin
      exp_q   = '1;
      exp_r   = a;
      exp_dz  = 1'b1;
      exp_lat = 4;
    end else begin
      exp_q   = a / b;
      exp_r   = a % b;
      exp_dz  = 1'b0;
      exp_lat = 3 + int'(exp_q) + 1;
    end
    start_and_load(a, b, tag);
    n = 3;
    while (!done && n < exp_lat + 5) begin
      @(negedge clk);
      data_in = W'($urandom);
      start   = (n + 1 == pulse_n);
      @(posedge clk);
      n++;
      #1;
      check({tag, " busy&done"}, 32'(busy & done), 32'd0);
    end
    start = 1'b0;
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    check({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, b;
    rst_n   = 1'b0;
    start   = 1'b0;
    data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset quotient", 32'(quotient), 32'd0);
    check("reset remainder", 32'(remainder), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Nominal
    run_div(16'd9832, 16'd23, -1, "nominal");

    // Done holds without start
    repeat (3) @(posedge clk);
    #1;
    check("hold done", 32'(done), 32'd1);
    check("hold quotient", 32'(quotient), 32'd427);

    // Edge operands
    run_div(16'd5, 16'd7, -1, "lt");
    run_div(16'd23, 16'd23, -1, "eq");
    run_div(16'd65535, 16'd1, -1, "div1");

    // Divide by zero
    run_div(16'd100, 16'd0, -1, "dz");

    // Start pulsed during SUB is ignored
    run_div(16'd1000, 16'd3, 8, "ignore");
    run_div(16'd1000, 16'd3, 200, "ignore2");

    // Reset mid-SUB
    start_and_load(16'd500, 16'd1, "rst");
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst quotient", 32'(quotient), 32'd0);
    check("midrst remainder", 32'(remainder), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst dz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("postrst idle busy", 32'(busy), 32'd0);
    check("postrst idle done", 32'(done), 32'd0);
    run_div(16'd4711, 16'd13, -1, "postrst");

    // Random operands with a bounded quotient to keep run time short
    for (int i = 0; i < 500; i++) begin
      a = int'($urandom_range(0, 65535));
      case ($urandom_range(0, 2))
        0:       b = int'($urandom_range(1, 15));
        1:       b = int'($urandom_range(16, 4095));
        default: b = int'($urandom_range(4096, 65535));
      endcase
      if (a / b > 16) a = b * 16 + a % b;
      run_div(W'(a), W'(b), -1, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
